// File: rtl/dims_addsub_ctrl.sv
// dims_addsub_ctrl: dual-rail DIMS ripple adder/subtractor with a clocked
// four-phase controller.
// Single-rail operands are encoded onto flop-driven dual-rail wires. Completion
// and the return-to-NULL are detected through synchronisers. The single-rail
// result is returned over a valid/ready handshake.
// Optional feature: define DIMS_ADDSUB_TIMEOUT_EN to build the per-phase
// watchdog. Without it, EVAL and RTZ wait indefinitely.

// One DIMS full-adder cell.
// Every rail input changes only on a clock edge, so each three-input
// C-element collapses to an AND of its inputs. In this cell, PI carries no
// logic function.
module fa_dims (
   input  logic pi,
   input  logic a_t,
   input  logic a_f,
   input  logic b_t,
   input  logic b_f,
   input  logic ci_t,
   input  logic ci_f,
   output logic s_t,
   output logic s_f,
   output logic co_t,
   output logic co_f
);

   logic pi_unused;
   logic [7:0] m;

   assign pi_unused = pi;

   // Minterm detection: m[{a,b,c}] fires once all three inputs hold DATA.
   always_comb begin
      m[0] = a_f & b_f & ci_f;
      m[1] = a_f & b_f & ci_t;
      m[2] = a_f & b_t & ci_f;
      m[3] = a_f & b_t & ci_t;
      m[4] = a_t & b_f & ci_f;
      m[5] = a_t & b_f & ci_t;
      m[6] = a_t & b_t & ci_f;
      m[7] = a_t & b_t & ci_t;
   end

   assign s_t  = m[1] | m[2] | m[4] | m[7];
   assign s_f  = m[0] | m[3] | m[5] | m[6];
   assign co_t = m[3] | m[5] | m[6] | m[7];
   assign co_f = m[0] | m[1] | m[2] | m[4];

endmodule

module dims_addsub_ctrl #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PI,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_err
);

   typedef enum logic [1:0] {IDLE, EVAL, RTZ, OUT} state_t;

   state_t state;
   state_t next_state;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             sub_q;

   logic [WIDTH-1:0] a_t;
   logic [WIDTH-1:0] a_f;
   logic [WIDTH-1:0] b_t;
   logic [WIDTH-1:0] b_f;
   logic             ci_t;
   logic             ci_f;

   logic [WIDTH-1:0] bx_t;
   logic [WIDTH-1:0] bx_f;
   logic [WIDTH:0]   c_t;
   logic [WIDTH:0]   c_f;
   logic [WIDTH-1:0] s_t;
   logic [WIDTH-1:0] s_f;

   logic raw_valid;
   logic raw_null;
   logic raw_illegal;

   logic [SYNC_STAGES-1:0] sync_valid_sr;
   logic [SYNC_STAGES-1:0] sync_null_sr;
   logic [SYNC_STAGES-1:0] sync_illegal_sr;
   logic sync_valid;
   logic sync_null;
   logic sync_illegal;

   logic drive_data;
   logic timeout_hit;

   // Subtraction inverts B by swapping its rails. The select is a register
   // that is stable for the whole transaction.
   assign bx_t = sub_q ? b_f : b_t;
   assign bx_f = sub_q ? b_t : b_f;
   assign c_t[0] = ci_t;
   assign c_f[0] = ci_f;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_dims u_fa (
         .pi   (PI),
         .a_t  (a_t[i]),
         .a_f  (a_f[i]),
         .b_t  (bx_t[i]),
         .b_f  (bx_f[i]),
         .ci_t (c_t[i]),
         .ci_f (c_f[i]),
         .s_t  (s_t[i]),
         .s_f  (s_f[i]),
         .co_t (c_t[i+1]),
         .co_f (c_f[i+1])
      );
   end

   // Completion, spacer and illegal-code detection over every sum and carry
   // rail pair.
   always_comb begin
      raw_valid   = &({s_t, c_t[WIDTH:1]} | {s_f, c_f[WIDTH:1]});
      raw_null    = ~|{s_t, s_f, c_t[WIDTH:1], c_f[WIDTH:1]};
      raw_illegal = |({s_t, c_t[WIDTH:1]} & {s_f, c_f[WIDTH:1]});
   end

   // The detectors pass through flop chains before the FSM sees them. The
   // NULL chain resets high because the rails are NULL during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_valid_sr   <= '0;
         sync_null_sr    <= '1;
         sync_illegal_sr <= '0;
      end else begin
         sync_valid_sr   <= {sync_valid_sr[SYNC_STAGES-2:0], raw_valid};
         sync_null_sr    <= {sync_null_sr[SYNC_STAGES-2:0], raw_null};
         sync_illegal_sr <= {sync_illegal_sr[SYNC_STAGES-2:0], raw_illegal};
      end
   end

   assign sync_valid   = sync_valid_sr[SYNC_STAGES-1];
   assign sync_null    = sync_null_sr[SYNC_STAGES-1];
   assign sync_illegal = sync_illegal_sr[SYNC_STAGES-1];

`ifdef DIMS_ADDSUB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] wd_cnt;

   // Per-phase watchdog: clears on every state change and counts only while
   // the controller waits in EVAL or RTZ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (next_state != state) begin
         wd_cnt <= '0;
      end else if (state == EVAL || state == RTZ) begin
         wd_cnt <= wd_cnt + 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end

   assign timeout_hit = (state == EVAL || state == RTZ) &&
                        (wd_cnt == CW'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Four-phase sequencing: launch DATA, wait for valid, return to NULL, then
   // hand off the result.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (in_valid)                  next_state = EVAL;
         EVAL: if (sync_valid || timeout_hit) next_state = RTZ;
         RTZ:  if (sync_null || timeout_hit)  next_state = OUT;
         OUT:  if (out_ready)                 next_state = IDLE;
         default:                             next_state = IDLE;
      endcase
   end

   // Handshake outputs. in_ready is held low for as long as reset is asserted.
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == OUT);
   end

   // Operands are captured on the accept edge. They launch onto the rails one
   // cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         sub_q <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_q   <= in_a;
         b_q   <= in_b;
         sub_q <= in_sub;
      end
   end

   assign drive_data = (state == EVAL) && (next_state == EVAL);

   // Rail drive flops hold DATA while EVAL continues. They return to NULL
   // (all zero) on every other cycle and immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_t  <= '0;
         a_f  <= '0;
         b_t  <= '0;
         b_f  <= '0;
         ci_t <= 1'b0;
         ci_f <= 1'b0;
      end else if (drive_data) begin
         a_t  <= a_q;
         a_f  <= ~a_q;
         b_t  <= b_q;
         b_f  <= ~b_q;
         ci_t <= sub_q;
         ci_f <= ~sub_q;
      end else begin
         a_t  <= '0;
         a_f  <= '0;
         b_t  <= '0;
         b_f  <= '0;
         ci_t <= 1'b0;
         ci_f <= 1'b0;
      end
   end

   // The result is captured once synchronised completion is seen. A watchdog
   // expiry instead reports an error, with a zero result if it happens in EVAL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_err  <= 1'b0;
      end else if (state == EVAL && sync_valid) begin
         out_sum  <= s_t;
         out_cout <= c_t[WIDTH];
         out_err  <= sync_illegal;
      end else if (state == EVAL && timeout_hit) begin
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_err  <= 1'b1;
      end else if (state == RTZ && timeout_hit && !sync_null) begin
         out_err  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dims_addsub_ctrl.sv
// Testbench for dims_addsub_ctrl.
// It applies table-driven add/subtract vectors and then a set of hand-written
// corner sequences: output stall, reset during EVAL, and a stuck rail with or
// without DIMS_ADDSUB_TIMEOUT_EN.
module tb_dims_addsub_ctrl;

   localparam int WIDTH   = 8;
   localparam int SYNC    = 2;
   localparam int TMO     = 16;
   localparam int MIN_LAT = 2 * SYNC + 3;
   localparam int MAX_LAT = 60;

   logic             clk = 1'b0;
   logic             rst;
   logic             pi;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_err;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs [10];

   dims_addsub_ctrl #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC),
      .TIMEOUT     (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .PI        (pi),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_err   (out_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case a sequence wedges.
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (!in_ready && guard < 100) begin
         step();
         guard++;
      end
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < MAX_LAT) begin
         step();
         lat++;
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic sub, output logic [7:0] sum,
                                 output logic cout, output logic err,
                                 output int lat);
      wait_ready();
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_out(lat);
      sum       = out_sum;
      cout      = out_cout;
      err       = out_err;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] sum;
      logic       cout;
      logic       err;
      int         lat;
      logic       bad;

      vecs[0] = '{a: 8'h3C, b: 8'h05, sub: 1'b0, sum: 8'h41, cout: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, cout: 1'b1};
      vecs[2] = '{a: 8'h05, b: 8'h07, sub: 1'b1, sum: 8'hFE, cout: 1'b0};
      vecs[3] = '{a: 8'h07, b: 8'h05, sub: 1'b1, sum: 8'h02, cout: 1'b1};
      vecs[4] = '{a: 8'hAA, b: 8'h55, sub: 1'b0, sum: 8'hFF, cout: 1'b0};
      vecs[5] = '{a: 8'h80, b: 8'h80, sub: 1'b0, sum: 8'h00, cout: 1'b1};
      vecs[6] = '{a: 8'h00, b: 8'h00, sub: 1'b1, sum: 8'h00, cout: 1'b1};
      vecs[7] = '{a: 8'h00, b: 8'h01, sub: 1'b1, sum: 8'hFF, cout: 1'b0};
      vecs[8] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, cout: 1'b0};
      vecs[9] = '{a: 8'hFF, b: 8'hFF, sub: 1'b1, sum: 8'h00, cout: 1'b1};

      rst       = 1'b1;
      pi        = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      out_ready = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_in_ready", 32'(in_ready), 32'd0);
      check_output("reset_out_valid", 32'(out_valid), 32'd0);
      check_output("reset_out_sum", 32'(out_sum), 32'd0);
      check_output("reset_out_cout", 32'(out_cout), 32'd0);
      check_output("reset_out_err", 32'(out_err), 32'd0);
      check_output("reset_rails", 32'(|{dut.a_t, dut.a_f, dut.b_t, dut.b_f,
                                        dut.ci_t, dut.ci_f}), 32'd0);
      rst = 1'b0;
      #1;
      check_output("release_in_ready", 32'(in_ready), 32'd1);
      step();

      // Table-driven arithmetic vectors.
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sub, sum, cout, err, lat);
         check_output($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
         check_output($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
         check_output($sformatf("vec%0d_err", i), 32'(err), 32'd0);
         check_output($sformatf("vec%0d_lat_min", i), 32'(lat >= MIN_LAT), 32'd1);
         check_output($sformatf("vec%0d_lat_max", i), 32'(lat < MAX_LAT), 32'd1);
      end

      // Output stall: in OUT with in_valid high, nothing new may start.
      wait_ready();
      in_a     = 8'h12;
      in_b     = 8'h34;
      in_sub   = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_out(lat);
      check_output("stall_reach_out", 32'(out_valid), 32'd1);
      in_a     = 8'h01;
      in_b     = 8'h01;
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         check_output($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
         check_output($sformatf("stall%0d_sum", k), 32'(out_sum), 32'h46);
         check_output($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_output("post_stall_idle_ready", 32'(in_ready), 32'd1);
      check_output("post_stall_valid_low", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      wait_out(lat);
      check_output("post_stall_valid", 32'(out_valid), 32'd1);
      check_output("post_stall_sum", 32'(out_sum), 32'h02);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Reset asserted while EVAL is driving DATA rails.
      wait_ready();
      in_a     = 8'h55;
      in_b     = 8'h0F;
      in_sub   = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check_output("eval_rails_data", 32'(|{dut.a_t, dut.a_f}), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_output("rst_eval_rails", 32'(|{dut.a_t, dut.a_f, dut.b_t, dut.b_f,
                                          dut.ci_t, dut.ci_f}), 32'd0);
      check_output("rst_eval_out_valid", 32'(out_valid), 32'd0);
      step();
      rst = 1'b0;
      step();
      apply_stimulus(8'h10, 8'h20, 1'b0, sum, cout, err, lat);
      check_output("after_rst_sum", 32'(sum), 32'h30);
      check_output("after_rst_cout", 32'(cout), 32'd0);

      // Stuck sum rail: bit 3 of 0x08 can never become valid.
      wait_ready();
      force dut.s_t = 8'h00;
      in_a     = 8'h08;
      in_b     = 8'h00;
      in_sub   = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
`ifdef DIMS_ADDSUB_TIMEOUT_EN
      repeat (TMO - 1) step();
      check_output("wd_not_yet_err", 32'(out_err), 32'd0);
      step();
      check_output("wd_err", 32'(out_err), 32'd1);
      check_output("wd_sum_zero", 32'(out_sum), 32'd0);
      wait_out(lat);
      check_output("wd_out_valid", 32'(out_valid), 32'd1);
      check_output("wd_out_err", 32'(out_err), 32'd1);
      check_output("wd_out_sum", 32'(out_sum), 32'd0);
      check_output("wd_out_cout", 32'(out_cout), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      release dut.s_t;
      check_output("wd_back_idle", 32'(in_ready), 32'd1);
`else
      bad = 1'b0;
      repeat (40) begin
         step();
         if (out_valid || in_ready) bad = 1'b1;
      end
      check_output("stuck_no_progress", 32'(bad), 32'd0);
      release dut.s_t;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check_output("stuck_reset_ready", 32'(in_ready), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
